spi_cmd_frame_decoder: RTL and testbench

//  Consumes 16-bit words from spi_slave_core (rx_data/rx_valid) and parses them as command frames.

---
 rtl/spi_cmd_pkg.sv | 35 +++
 rtl/crc16_ccitt_word.sv | 27 ++
 rtl/spi_cmd_frame_decoder.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_spi_cmd_frame_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command frame decoder: FSM state encoding,
// error codes, header layout and CRC-16/CCITT constants.
package spi_cmd_pkg;

  // FSM state encoding
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WR_DATA   = 4'd1;
  localparam logic [3:0] ST_WR_CRC    = 4'd2;
  localparam logic [3:0] ST_WR_COMMIT = 4'd3;
  localparam logic [3:0] ST_RD_REQ    = 4'd4;
  localparam logic [3:0] ST_RD_WAIT   = 4'd5;
  localparam logic [3:0] ST_RD_SHIFT  = 4'd6;
  localparam logic [3:0] ST_DONE      = 4'd7;
  localparam logic [3:0] ST_DRAIN     = 4'd8;

  // Error codes reported on o_err_code
  localparam logic [2:0] ERR_OK         = 3'd0;
  localparam logic [2:0] ERR_LEN        = 3'd1;
  localparam logic [2:0] ERR_RD_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_CS_ABORT   = 3'd3;
  localparam logic [2:0] ERR_CRC        = 3'd4;
  localparam logic [2:0] ERR_OVERRUN    = 3'd5;

  // CRC-16/CCITT
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Header word: [15] read/not-write, [14:8] start address, [7:0] word count
  typedef struct packed {
    logic       rd;
    logic [6:0] addr;
    logic [7:0] len;
  } hdr_t;

endpackage

// File: rtl/crc16_ccitt_word.sv
// Combinational CRC-16/CCITT update consuming one 16-bit word, MSB first.
// Only instantiated when SPI_CMD_CRC_EN is defined.
module crc16_ccitt_word
  import spi_cmd_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [15:0] i_data,
  output logic [15:0] o_crc
);

  logic [15:0] w_crc;

  // Sixteen serial shift/xor steps unrolled into one combinational stage
  always_comb begin
    w_crc = i_crc;
    for (int i = 15; i >= 0; i--) begin
      if (w_crc[15] ^ i_data[i]) begin
        w_crc = {w_crc[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        w_crc = {w_crc[14:0], 1'b0};
      end
    end
  end

  assign o_crc = w_crc;

endmodule

// File: rtl/spi_cmd_frame_decoder.sv
// SPI command frame decoder: parses 16-bit words from the SPI slave core into
// register-bank read/write bursts with auto-incrementing address, and feeds
// read data back to the core for shifting out on MISO.
// Optional feature macro: SPI_CMD_CRC_EN (CRC-protected, staged write frames
// and a trailing CRC word on read frames).
module spi_cmd_frame_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_spi_active,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_load,
  output logic [ADDR_WIDTH-1:0] o_reg_addr,
  output logic [DATA_WIDTH-1:0] o_reg_wdata,
  output logic                  o_reg_wr_en,
  output logic                  o_reg_rd_en,
  input  logic [DATA_WIDTH-1:0] i_reg_rdata,
  input  logic                  i_reg_rd_valid,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic [2:0]            o_err_code
);

  localparam int unsigned   CW              = $clog2(MAX_BURST + 1);
  localparam int unsigned   TW              = $clog2(RD_TIMEOUT + 1);
  localparam logic [7:0]    LP_MAX_LEN      = 8'(MAX_BURST);
  localparam logic [TW-1:0] LP_TIMEOUT_LAST = TW'(RD_TIMEOUT - 1);

  logic [3:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr_ptr;
  logic [CW-1:0]         r_len;
  logic [CW-1:0]         r_count;
  logic [TW-1:0]         r_timer;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_load;
  logic [ADDR_WIDTH-1:0] r_reg_addr;
  logic [DATA_WIDTH-1:0] r_reg_wdata;
  logic                  r_reg_wr_en;
  logic                  r_reg_rd_en;
  logic                  r_frame_done;
  logic                  r_frame_err;
  logic [2:0]            r_err_code;

  hdr_t                  w_hdr;
  logic                  w_len_ok;
  logic [CW-1:0]         w_count_inc;

  assign w_hdr       = hdr_t'(i_rx_data);
  assign w_len_ok    = (w_hdr.len != 8'd0) && (w_hdr.len <= LP_MAX_LEN);
  assign w_count_inc = r_count + 1'b1;

`ifdef SPI_CMD_CRC_EN
  localparam int unsigned IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [DATA_WIDTH-1:0] r_buf [MAX_BURST];
  logic [15:0]           r_crc;
  logic                  r_is_rd;
  logic [15:0]           w_crc_seed;
  logic [15:0]           w_crc_word;
  logic [15:0]           w_crc_next;

  // Header starts a fresh CRC; read frames accumulate returned register data
  assign w_crc_seed = (r_state == ST_IDLE) ? CRC_INIT : r_crc;
  assign w_crc_word = (r_state == ST_RD_WAIT) ? i_reg_rdata : i_rx_data;

  crc16_ccitt_word u_crc (
    .i_crc  (w_crc_seed),
    .i_data (w_crc_word),
    .o_crc  (w_crc_next)
  );

  // Stage write data until the trailing CRC has been checked
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst && (r_state == ST_WR_DATA) && i_rx_valid) begin
      r_buf[r_count[IW-1:0]] <= i_rx_data;
    end
  end
`endif

  // Frame FSM with registered strobes; every strobe defaults low each cycle
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state      <= ST_IDLE;
      r_addr_ptr   <= '0;
      r_len        <= '0;
      r_count      <= '0;
      r_timer      <= '0;
      r_tx_data    <= '0;
      r_tx_load    <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_wdata  <= '0;
      r_reg_wr_en  <= 1'b0;
      r_reg_rd_en  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= ERR_OK;
`ifdef SPI_CMD_CRC_EN
      r_crc        <= CRC_INIT;
      r_is_rd      <= 1'b0;
`endif
    end else begin
      r_tx_load    <= 1'b0;
      r_reg_wr_en  <= 1'b0;
      r_reg_rd_en  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            r_addr_ptr <= w_hdr.addr;
            r_len      <= w_hdr.len[CW-1:0];
            r_count    <= '0;
`ifdef SPI_CMD_CRC_EN
            r_is_rd    <= w_hdr.rd;
            r_crc      <= w_hdr.rd ? CRC_INIT : w_crc_next;
`endif
            if (!w_len_ok) begin
              r_err_code  <= ERR_LEN;
              r_frame_err <= 1'b1;
              r_state     <= ST_DRAIN;
            end else begin
              r_err_code <= ERR_OK;
              r_state    <= w_hdr.rd ? ST_RD_REQ : ST_WR_DATA;
            end
          end
        end

        ST_WR_DATA: begin
          if (i_rx_valid) begin
            // A word arriving together with CS release is still accepted
`ifdef SPI_CMD_CRC_EN
            r_crc       <= w_crc_next;
`else
            r_reg_wr_en <= 1'b1;
            r_reg_addr  <= r_addr_ptr;
            r_reg_wdata <= i_rx_data;
            r_addr_ptr  <= r_addr_ptr + 1'b1;
`endif
            r_count <= w_count_inc;
            if (w_count_inc == r_len) begin
`ifdef SPI_CMD_CRC_EN
              r_state <= ST_WR_CRC;
`else
              r_state <= ST_DONE;
`endif
            end else if (!i_spi_active) begin
              r_err_code  <= ERR_CS_ABORT;
              r_frame_err <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end else if (!i_spi_active) begin
            r_err_code  <= ERR_CS_ABORT;
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

`ifdef SPI_CMD_CRC_EN
        ST_WR_CRC: begin
          if (i_rx_valid) begin
            if (i_rx_data == r_crc) begin
              r_count <= '0;
              r_state <= ST_WR_COMMIT;
            end else begin
              r_err_code  <= ERR_CRC;
              r_frame_err <= 1'b1;
              r_state     <= ST_DRAIN;
            end
          end else if (!i_spi_active) begin
            r_err_code  <= ERR_CS_ABORT;
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        // CRC already validated: the burst commits atomically, CS is ignored
        ST_WR_COMMIT: begin
          r_reg_wr_en <= 1'b1;
          r_reg_addr  <= r_addr_ptr;
          r_reg_wdata <= r_buf[r_count[IW-1:0]];
          r_addr_ptr  <= r_addr_ptr + 1'b1;
          r_count     <= w_count_inc;
          if (w_count_inc == r_len) begin
            r_state <= ST_DONE;
          end
        end
`endif

        ST_RD_REQ: begin
          if (!i_spi_active) begin
            r_err_code  <= ERR_CS_ABORT;
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_reg_rd_en <= 1'b1;
            r_reg_addr  <= r_addr_ptr;
            r_timer     <= '0;
            r_state     <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (i_rx_valid) begin
            // Master clocked a word before read data was ready to send
            r_err_code  <= ERR_OVERRUN;
            r_frame_err <= 1'b1;
            r_state     <= ST_DRAIN;
          end else if (!i_spi_active) begin
            r_err_code  <= ERR_CS_ABORT;
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (i_reg_rd_valid) begin
            r_tx_data <= i_reg_rdata;
            r_tx_load <= 1'b1;
`ifdef SPI_CMD_CRC_EN
            r_crc     <= w_crc_next;
`endif
            r_state   <= ST_RD_SHIFT;
          end else if (r_timer == LP_TIMEOUT_LAST) begin
            r_err_code  <= ERR_RD_TIMEOUT;
            r_frame_err <= 1'b1;
            r_state     <= ST_DRAIN;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_RD_SHIFT: begin
          if (i_rx_valid) begin
            // Dummy MOSI word; its transfer carried the previously loaded data
            r_count <= w_count_inc;
            if (w_count_inc == r_len) begin
              r_state <= ST_DONE;
            end else if (!i_spi_active) begin
              r_err_code  <= ERR_CS_ABORT;
              r_frame_err <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_addr_ptr <= r_addr_ptr + 1'b1;
              r_state    <= ST_RD_REQ;
            end
          end else if (!i_spi_active) begin
            r_err_code  <= ERR_CS_ABORT;
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        ST_DONE: begin
          r_frame_done <= 1'b1;
`ifdef SPI_CMD_CRC_EN
          if (r_is_rd) begin
            r_tx_data <= r_crc;
            r_tx_load <= 1'b1;
          end else begin
            r_tx_data <= '0;
          end
`else
          r_tx_data <= '0;
`endif
          r_state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (!i_spi_active) begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_tx_load    = r_tx_load;
  assign o_reg_addr   = r_reg_addr;
  assign o_reg_wdata  = r_reg_wdata;
  assign o_reg_wr_en  = r_reg_wr_en;
  assign o_reg_rd_en  = r_reg_rd_en;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_spi_cmd_frame_decoder.sv
// Scoreboard bench for spi_cmd_frame_decoder: stimulus pushes expected writes,
// reads, tx words and frame outcomes; monitor and register responder pop them.
// Honours SPI_CMD_CRC_EN when the design is built with it.
module tb_spi_cmd_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        spi_active;
  logic [15:0] tx_data;
  logic        tx_load;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [15:0] reg_rdata;
  logic        reg_rd_valid;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  spi_cmd_frame_decoder dut (
    .i_sys_clk      (clk),
    .i_sys_rst      (rst),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .i_spi_active   (spi_active),
    .o_tx_data      (tx_data),
    .o_tx_load      (tx_load),
    .o_reg_addr     (reg_addr),
    .o_reg_wdata    (reg_wdata),
    .o_reg_wr_en    (reg_wr_en),
    .o_reg_rd_en    (reg_rd_en),
    .i_reg_rdata    (reg_rdata),
    .i_reg_rd_valid (reg_rd_valid),
    .o_frame_done   (frame_done),
    .o_frame_err    (frame_err),
    .o_err_code     (err_code)
  );

  typedef struct {logic [6:0] addr; logic [15:0] data;} wr_t;
  typedef struct {logic [6:0] addr; logic [15:0] data; bit respond;} rd_t;

  wr_t         q_wr[$];
  rd_t         q_rd[$];
  logic [15:0] q_tx[$];
  int          q_ev[$];   // 0 = frame_done, otherwise expected error code

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rd_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: strobe seen, expected none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Monitor: compare every DUT strobe against the scoreboard queues
  initial begin
    wr_t w;
    int  e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reg_rd_en === 1'b1) last_rd_cyc = cyc;
      if (reg_wr_en === 1'b1) begin
        if (q_wr.size() == 0) unexpected("wr_en");
        else begin
          w = q_wr.pop_front();
          check("wr_addr", 32'(reg_addr), 32'(w.addr));
          check("wr_data", 32'(reg_wdata), 32'(w.data));
        end
      end
      if (tx_load === 1'b1) begin
        if (q_tx.size() == 0) unexpected("tx_load");
        else check("tx_data", 32'(tx_data), 32'(q_tx.pop_front()));
      end
      if (frame_done === 1'b1 && frame_err === 1'b1) unexpected("done_and_err");
      if (frame_done === 1'b1) begin
        if (q_ev.size() == 0) unexpected("frame_done");
        else begin
          e = q_ev.pop_front();
          check("done_expected_event", 32'd0, 32'(e));
          check("done_err_code", 32'(err_code), 32'd0);
        end
      end else if (frame_err === 1'b1) begin
        if (q_ev.size() == 0) unexpected("frame_err");
        else begin
          e = q_ev.pop_front();
          check("err_code", 32'(err_code), 32'(e));
          if (e == 2) check("timeout_latency", 32'(cyc - last_rd_cyc), 32'd64);
        end
      end
    end
  end

  // Register-bank model: answers rd_en three cycles later unless told to stay mute
  initial begin
    rd_t         r;
    int          cd = 0;
    logic [15:0] pend = '0;
    reg_rd_valid = 1'b0;
    reg_rdata    = '0;
    forever begin
      @(negedge clk);
      reg_rd_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          reg_rd_valid = 1'b1;
          reg_rdata    = pend;
        end
      end
      if (reg_rd_en === 1'b1) begin
        if (q_rd.size() == 0) unexpected("rd_en");
        else begin
          r = q_rd.pop_front();
          check("rd_addr", 32'(reg_addr), 32'(r.addr));
          if (r.respond) begin
            cd   = 3;
            pend = r.data;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [15:0] w, input int gap);
    @(negedge clk);
    rx_data  = w;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word_cs_drop(input logic [15:0] w);
    @(negedge clk);
    rx_data    = w;
    rx_valid   = 1'b1;
    spi_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_on();
    @(negedge clk);
    spi_active = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_off();
    @(negedge clk);
    spi_active = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    rx_data    = '0;
    rx_valid   = 1'b0;
    spi_active = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_reg_addr", 32'(reg_addr), 32'h0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
    check("rst_err_code", 32'(err_code), 32'h0);
    check("rst_strobes", {27'd0, tx_load, reg_wr_en, reg_rd_en, frame_done, frame_err}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write burst of two words
    q_wr.push_back('{7'h0A, 16'h1234});
    q_wr.push_back('{7'h0B, 16'hBEEF});
    q_ev.push_back(0);
    cs_on();
    send_word(16'h0A02, 6);
    send_word(16'h1234, 6);
    send_word(16'hBEEF, 6);
`ifdef SPI_CMD_CRC_EN
    send_word(crc16(crc16(crc16(16'hFFFF, 16'h0A02), 16'h1234), 16'hBEEF), 6);
`endif
    cs_off();

    // Read burst of three words
    q_rd.push_back('{7'h05, 16'h1111, 1'b1});
    q_rd.push_back('{7'h06, 16'h2222, 1'b1});
    q_rd.push_back('{7'h07, 16'h3333, 1'b1});
    q_tx.push_back(16'h1111);
    q_tx.push_back(16'h2222);
    q_tx.push_back(16'h3333);
`ifdef SPI_CMD_CRC_EN
    q_tx.push_back(crc16(crc16(crc16(16'hFFFF, 16'h1111), 16'h2222), 16'h3333));
`endif
    q_ev.push_back(0);
    cs_on();
    send_word(16'h8503, 12);
    for (int i = 0; i < 3; i++) send_word(16'h0000, 12);
`ifdef SPI_CMD_CRC_EN
    send_word(16'h0000, 6);
`endif
    cs_off();

    // Address wraps from 0x7F to 0x00
    q_wr.push_back('{7'h7F, 16'hAAAA});
    q_wr.push_back('{7'h00, 16'h5555});
    q_ev.push_back(0);
    cs_on();
    send_word(16'h7F02, 6);
    send_word(16'hAAAA, 6);
    send_word(16'h5555, 6);
`ifdef SPI_CMD_CRC_EN
    send_word(crc16(crc16(crc16(16'hFFFF, 16'h7F02), 16'hAAAA), 16'h5555), 6);
`endif
    cs_off();

    // LEN = 0: error 1, following words ignored, code held after CS release
    q_ev.push_back(1);
    cs_on();
    send_word(16'h0100, 4);
    send_word(16'h1234, 4);
    send_word(16'h8001, 4);
    check("len0_err_code", 32'(err_code), 32'd1);
    cs_off();
    check("len0_err_held", 32'(err_code), 32'd1);

    // LEN = 9: error 1
    q_ev.push_back(1);
    cs_on();
    send_word(16'h0009, 4);
    send_word(16'h4444, 4);
    cs_off();

    // CS released after two of four data words
`ifndef SPI_CMD_CRC_EN
    q_wr.push_back('{7'h00, 16'h0001});
    q_wr.push_back('{7'h00 + 7'h01, 16'h0002});
`endif
    q_ev.push_back(3);
    cs_on();
    send_word(16'h0004, 4);
    send_word(16'h0001, 4);
    send_word(16'h0002, 4);
    cs_off();

    // Register never answers: timeout after 64 cycles
    q_rd.push_back('{7'h10, 16'h0000, 1'b0});
    q_ev.push_back(2);
    cs_on();
    send_word(16'h9001, 80);
    cs_off();

    // Master clocks a word before read data is ready: overrun
    q_rd.push_back('{7'h20, 16'h0000, 1'b0});
    q_ev.push_back(5);
    cs_on();
    send_word(16'hA001, 2);
    send_word(16'h0000, 4);
    cs_off();

    // Last data word arrives together with CS release
`ifdef SPI_CMD_CRC_EN
    q_ev.push_back(3);
`else
    q_wr.push_back('{7'h20, 16'h7777});
    q_ev.push_back(0);
`endif
    cs_on();
    send_word(16'h2001, 4);
    send_word_cs_drop(16'h7777);

`ifdef SPI_CMD_CRC_EN
    // Corrupted CRC: nothing committed, error 4
    q_ev.push_back(4);
    cs_on();
    send_word(16'h3002, 4);
    send_word(16'h0001, 4);
    send_word(16'h0002, 4);
    send_word(crc16(crc16(crc16(16'hFFFF, 16'h3002), 16'h0001), 16'h0002) ^ 16'h0001, 4);
    cs_off();
`endif

    // Reset mid-frame, then a fresh frame under the same CS
`ifndef SPI_CMD_CRC_EN
    q_wr.push_back('{7'h40, 16'h0001});
`endif
    cs_on();
    send_word(16'h4003, 4);
    send_word(16'h0001, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_strobes", {27'd0, tx_load, reg_wr_en, reg_rd_en, frame_done, frame_err}, 32'h0);
    check("midrst_err_code", 32'(err_code), 32'h0);
    rst = 1'b0;
    q_wr.push_back('{7'h41, 16'h9999});
    q_ev.push_back(0);
    send_word(16'h4101, 4);
    send_word(16'h9999, 4);
`ifdef SPI_CMD_CRC_EN
    send_word(crc16(crc16(16'hFFFF, 16'h4101), 16'h9999), 4);
`endif
    cs_off();

    repeat (20) @(negedge clk);
    check("left_wr", 32'(q_wr.size()), 32'd0);
    check("left_rd", 32'(q_rd.size()), 32'd0);
    check("left_tx", 32'(q_tx.size()), 32'd0);
    check("left_ev", 32'(q_ev.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
